// File: rtl/gba_mem_ctrl.sv
// rtl/gba_mem_ctrl.sv - GBA system-bus memory controller: region decode, lane rules, wait states
module gba_mem_ctrl #(
  parameter int BIOS_AW      = 12,
  parameter int EWRAM_AW     = 16,
  parameter int IWRAM_AW     = 13,
  parameter int PAK_AW       = 8,
  parameter int CART_AW      = 16,
  parameter int WS_BIOS      = 0,
  parameter int WS_EWRAM     = 2,
  parameter int WS_IWRAM     = 0,
  parameter int WS_PAK       = 4,
  parameter int WS_CART      = 4,
  parameter int PAK_WRITABLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  width,
  input  logic        read,
  input  logic        write,
  output logic [31:0] rdata,
  output logic        ok,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [2:0] {R_BIOS, R_EWRAM, R_IWRAM, R_PAK, R_CART, R_NONE} region_t;

  state_t      state, state_nx;
  region_t     region_in, region_q;
  logic [3:0]  ws_in, wcnt;
  logic [31:0] addr_q, wdata_q, ra, bus_word, ew_word, iw_word, pak_word;
  logic [1:0]  width_q;
  logic        write_q, err_q, accept, dual, do_wr;
  logic [3:0]  be;
  logic [7:0]  cart_q;
  logic [7:0]  cart_mem [2**CART_AW];
  logic        unused_bits;

  if (BIOS_AW < 1 || WS_BIOS < 0 || WS_BIOS > 15 || WS_EWRAM < 0 || WS_EWRAM > 15 ||
      WS_IWRAM < 0 || WS_IWRAM > 15 || WS_PAK < 0 || WS_PAK > 15 ||
      WS_CART < 0 || WS_CART > 15) begin : g_param_check
    $error("gba_mem_ctrl: parameter out of range");
  end

  always_comb begin
    region_in = R_NONE;
    ws_in     = 4'd0;
    case (addr[27:24])
      4'h0: begin region_in = R_BIOS;  ws_in = 4'(WS_BIOS);  end
      4'h2: begin region_in = R_EWRAM; ws_in = 4'(WS_EWRAM); end
      4'h3: begin region_in = R_IWRAM; ws_in = 4'(WS_IWRAM); end
      4'h8, 4'h9, 4'ha, 4'hb, 4'hc, 4'hd: begin region_in = R_PAK; ws_in = 4'(WS_PAK); end
      4'he, 4'hf: begin region_in = R_CART; ws_in = 4'(WS_CART); end
      default: ;
    endcase
  end

  assign accept = (state == IDLE) && (read ^ write);
  assign dual   = (state == IDLE) && read && write;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept)    state_nx = (ws_in != 4'd0) ? WAIT : DONE;
        else if (dual) state_nx = DONE;
      end
      WAIT:    if (wcnt <= 4'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wcnt     <= 4'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      width_q  <= 2'd0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      region_q <= R_NONE;
    end else begin
      state <= state_nx;
      if (accept || dual) begin
        addr_q   <= addr;
        wdata_q  <= wdata;
        width_q  <= width;
        write_q  <= write & ~read;
        region_q <= dual ? R_NONE : region_in;
        err_q    <= dual || (region_in == R_NONE);
        wcnt     <= dual ? 4'd0 : ws_in;
      end else if (state == WAIT) begin
        wcnt <= wcnt - 4'd1;
      end
    end
  end

  // RAM read address comes straight from the bus on a zero-wait accept edge
  assign ra    = (state == IDLE) ? addr : addr_q;
  assign do_wr = (state == DONE) && write_q && !err_q;

  always_comb begin
    case (width_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] ew_mem  [2**EWRAM_AW];
    logic [7:0] iw_mem  [2**IWRAM_AW];
    logic [7:0] pak_mem [2**PAK_AW];
    logic [7:0] ew_q, iw_q, pak_q;

    always_ff @(posedge clk) begin
      if (do_wr && be[i]) begin
        if (region_q == R_EWRAM) ew_mem[addr_q[EWRAM_AW+1:2]] <= wdata_q[8*i +: 8];
        if (region_q == R_IWRAM) iw_mem[addr_q[IWRAM_AW+1:2]] <= wdata_q[8*i +: 8];
        if (region_q == R_PAK && PAK_WRITABLE != 0)
          pak_mem[addr_q[PAK_AW+1:2]] <= wdata_q[8*i +: 8];
      end
      ew_q  <= ew_mem[ra[EWRAM_AW+1:2]];
      iw_q  <= iw_mem[ra[IWRAM_AW+1:2]];
      pak_q <= pak_mem[ra[PAK_AW+1:2]];
    end

    assign ew_word[8*i +: 8]  = ew_q;
    assign iw_word[8*i +: 8]  = iw_q;
    assign pak_word[8*i +: 8] = pak_q;
  end

  // Cart bus is 8 bits wide: only the addressed lane is ever stored
  always_ff @(posedge clk) begin
    if (do_wr && region_q == R_CART) cart_mem[addr_q[CART_AW-1:0]] <= wdata_q[8*addr_q[1:0] +: 8];
    cart_q <= cart_mem[ra[CART_AW-1:0]];
  end

  // No BIOS image is held in this block: BIOS reads return zero and writes are dropped
  always_comb begin
    case (region_q)
      R_EWRAM: bus_word = ew_word;
      R_IWRAM: bus_word = iw_word;
      R_PAK:   bus_word = pak_word;
      R_CART:  bus_word = {4{cart_q}};
      default: bus_word = 32'h0;
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    if (state == DONE && !write_q && !err_q) begin
      case (width_q)
        2'd0:    rdata = {24'h0, bus_word[8*addr_q[1:0] +: 8]};
        2'd1:    rdata = {16'h0, bus_word[16*addr_q[1] +: 16]};
        default: rdata = bus_word;
      endcase
    end
  end

  assign ok  = (state == DONE);
  assign err = ok && err_q;

  assign unused_bits = ^{addr, addr_q, ra};

endmodule

// File: tb/tb_gba_mem_ctrl.sv
// tb/tb_gba_mem_ctrl.sv - self-checking bench for gba_mem_ctrl against a byte-level memory model
module tb_gba_mem_ctrl;

  localparam int BIOS_AW = 12, EWRAM_AW = 16, IWRAM_AW = 13, PAK_AW = 8, CART_AW = 16;
  localparam int WS_BIOS = 0, WS_EWRAM = 2, WS_IWRAM = 0, WS_PAK = 4, WS_CART = 4;
  localparam int PAK_WRITABLE = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic [1:0]  width;
  logic        rd_req, wr_req;
  logic [31:0] rdata;
  logic        ok, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mdl [int unsigned];

  gba_mem_ctrl #(
    .BIOS_AW(BIOS_AW), .EWRAM_AW(EWRAM_AW), .IWRAM_AW(IWRAM_AW), .PAK_AW(PAK_AW),
    .CART_AW(CART_AW), .WS_BIOS(WS_BIOS), .WS_EWRAM(WS_EWRAM), .WS_IWRAM(WS_IWRAM),
    .WS_PAK(WS_PAK), .WS_CART(WS_CART), .PAK_WRITABLE(PAK_WRITABLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .width(width),
    .read(rd_req), .write(wr_req), .rdata(rdata), .ok(ok), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit is_word_region(input logic [3:0] sel);
    return sel == 4'h2 || sel == 4'h3 || (sel >= 4'h8 && sel <= 4'hd);
  endfunction

  function automatic bit is_cart(input logic [3:0] sel);
    return sel >= 4'he;
  endfunction

  function automatic int ws_of(input logic [31:0] a, input bit r, input bit w);
    if (r && w) return 0;
    case (a[27:24])
      4'h0: return WS_BIOS;
      4'h2: return WS_EWRAM;
      4'h3: return WS_IWRAM;
      4'h8, 4'h9, 4'ha, 4'hb, 4'hc, 4'hd: return WS_PAK;
      4'he, 4'hf: return WS_CART;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned canon(input logic [31:0] a);
    case (a[27:24])
      4'h2: return 32'h0200_0000 + (a % (4 << EWRAM_AW));
      4'h3: return 32'h0300_0000 + (a % (4 << IWRAM_AW));
      4'he, 4'hf: return 32'h0e00_0000 + (a % (1 << CART_AW));
      default: return 32'h0800_0000 + (a % (4 << PAK_AW));
    endcase
  endfunction

  function automatic logic [7:0] mget(input int unsigned k);
    return mdl.exists(k) ? mdl[k] : 8'h00;
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wid);
    int lo, n;
    logic [3:0] sel;
    sel = a[27:24];
    if (is_cart(sel)) begin
      mdl[canon(a)] = 8'((wd >> (8 * (a % 4))) & 32'hff);
    end else if (is_word_region(sel) && !(sel >= 4'h8 && PAK_WRITABLE == 0)) begin
      if (wid == 2'd0)      begin lo = int'(a % 4);       n = 1; end
      else if (wid == 2'd1) begin lo = int'(a % 4) / 2 * 2; n = 2; end
      else                  begin lo = 0;                 n = 4; end
      for (int i = lo; i < lo + n; i++)
        mdl[canon((a / 4) * 4 + 32'(i))] = 8'((wd >> (8 * i)) & 32'hff);
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] a, input logic [1:0] wid);
    logic [31:0] w;
    logic [3:0]  sel;
    sel = a[27:24];
    w = 32'h0;
    if (is_cart(sel)) begin
      w = 32'(mget(canon(a))) * 32'h0101_0101;
    end else if (is_word_region(sel)) begin
      for (int i = 0; i < 4; i++)
        w = w | (32'(mget(canon((a / 4) * 4 + 32'(i)))) << (8 * i));
    end
    if (wid == 2'd0) return (w >> (8 * (a % 4))) & 32'hff;
    if (wid == 2'd1) return (w >> (16 * ((a / 2) % 2))) & 32'hffff;
    return w;
  endfunction

  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] wid, output logic [31:0] rd, output logic er,
                        output int lat);
    @(negedge clk);
    rd_req = r; wr_req = w; addr = a; wdata = wd; width = wid;
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ok) begin lat = i; rd = rdata; er = err; break; end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic check_access(input string name, input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [1:0] wid);
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    int lat, exp_lat;
    exp_lat = 1 + ws_of(a, r, w);
    exp_er  = (r && w) || !(a[27:24] == 4'h0 || is_word_region(a[27:24]) || is_cart(a[27:24]));
    exp_rd  = (r && !w && !exp_er) ? mdl_read(a, wid) : 32'h0;
    access(r, w, a, wd, wid, rd, er, lat);
    if (w && !r) mdl_write(a, wd, wid);
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++; $display("FAIL %s latency addr=%h got %0d want %0d", name, a, lat, exp_lat);
    end
    n_checks++;
    if (er !== exp_er) begin
      n_fail++; $display("FAIL %s err addr=%h got %b want %b", name, a, er, exp_er);
    end
    if (r) begin
      n_checks++;
      if (rd !== exp_rd) begin
        n_fail++; $display("FAIL %s rdata addr=%h got %h want %h", name, a, rd, exp_rd);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wdata = '0; width = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ok !== 1'b0)     begin n_fail++; $display("FAIL reset_ok got %b want 0", ok); end
    n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_iwram_word;
    check_access("iwram_wr", 0, 1, 32'h0300_0010, 32'hdead_beef, 2'd2);
    check_access("iwram_rd", 1, 0, 32'h0300_0010, 32'h0, 2'd2);
  endtask

  task automatic test_ewram_byte;
    check_access("ewram_init", 0, 1, 32'h0200_0000, 32'h1122_3344, 2'd2);
    check_access("ewram_bwr",  0, 1, 32'h0200_0003, 32'h5500_0000, 2'd0);
    check_access("ewram_wrd",  1, 0, 32'h0200_0000, 32'h0, 2'd2);
    check_access("ewram_brd",  1, 0, 32'h0200_0003, 32'h0, 2'd0);
  endtask

  task automatic test_halfword;
    check_access("half_init", 0, 1, 32'h0300_0010, 32'haabb_ccdd, 2'd2);
    check_access("half_hi",   1, 0, 32'h0300_0013, 32'h0, 2'd1);
    check_access("half_lo",   1, 0, 32'h0300_0010, 32'h0, 2'd1);
    check_access("half_wr",   0, 1, 32'h0300_0012, 32'h1234_5678, 2'd1);
    check_access("half_chk",  1, 0, 32'h0300_0010, 32'h0, 2'd2);
  endtask

  task automatic test_cart;
    check_access("cart_bwr", 0, 1, 32'h0e00_0001, 32'h0000_a500, 2'd0);
    check_access("cart_wrd", 1, 0, 32'h0e00_0001, 32'h0, 2'd2);
    check_access("cart_brd", 1, 0, 32'h0e00_0002, 32'h0, 2'd0);
  endtask

  task automatic test_errors;
    check_access("bios_wr",  0, 1, 32'h0000_0100, 32'h1357_9bdf, 2'd2);
    check_access("bios_rd",  1, 0, 32'h0000_0100, 32'h0, 2'd2);
    check_access("unmapped", 1, 0, 32'h0500_0000, 32'h0, 2'd2);
    check_access("dual",     1, 1, 32'h0300_0010, 32'hffff_ffff, 2'd2);
    check_access("dual_chk", 1, 0, 32'h0300_0010, 32'h0, 2'd2);
  endtask

  task automatic test_mirror;
    check_access("ew_mirror_wr", 0, 1, 32'h0204_0004, 32'h0bad_f00d, 2'd2);
    check_access("ew_mirror_rd", 1, 0, 32'h0200_0004, 32'h0, 2'd2);
    check_access("pak_mirror_wr", 0, 1, 32'h0800_0408, 32'hcafe_1234, 2'd2);
    check_access("pak_mirror_rd", 1, 0, 32'h0d00_0008, 32'h0, 2'd2);
  endtask

  task automatic test_reset_mid_wait;
    int oks;
    @(negedge clk);
    wr_req = 1'b1; addr = 32'h0200_0000; wdata = 32'hcafe_f00d; width = 2'd2;
    @(posedge clk);
    @(negedge clk);
    wr_req = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL midwait_ok got %b want 0", ok); end
    @(negedge clk); rst_n = 1'b1;
    oks = 0;
    repeat (6) begin @(posedge clk); #1; if (ok) oks++; end
    n_checks++; if (oks != 0) begin n_fail++; $display("FAIL midwait_stray_ok got %0d want 0", oks); end
    check_access("midwait_chk", 1, 0, 32'h0200_0000, 32'h0, 2'd2);
  endtask

  task automatic test_back_to_back(input logic [31:0] a);
    int last, pulses, ws;
    logic [31:0] exp;
    ws = ws_of(a, 1, 0);
    exp = mdl_read(a, 2'd2);
    last = -1; pulses = 0;
    @(negedge clk);
    rd_req = 1'b1; addr = a; width = 2'd2;
    for (int c = 0; c < 8 * (2 + ws); c++) begin
      @(posedge clk); #1;
      if (ok) begin
        n_checks++;
        if (rdata !== exp) begin n_fail++; $display("FAIL b2b_rdata addr=%h got %h want %h", a, rdata, exp); end
        if (last >= 0) begin
          n_checks++;
          if (c - last != 2 + ws) begin
            n_fail++; $display("FAIL b2b_gap addr=%h got %0d want %0d", a, c - last, 2 + ws);
          end
        end
        last = c; pulses++;
      end
    end
    rd_req = 1'b0;
    n_checks++;
    if (pulses < 7) begin n_fail++; $display("FAIL b2b_count addr=%h got %0d want >=7", a, pulses); end
    repeat (ws + 4) @(posedge clk);
  endtask

  function automatic logic [31:0] rand_addr(input int region);
    logic [31:0] off;
    off = 32'h100 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
    case (region)
      0: return 32'h0200_0000 + off + 32'($urandom_range(0, 3)) * (4 << EWRAM_AW);
      1: return 32'h0300_0000 + off + 32'($urandom_range(0, 3)) * (4 << IWRAM_AW);
      2: return {4'h0, 4'(8 + $urandom_range(0, 5)), 24'h0} + off + 32'($urandom_range(0, 3)) * (4 << PAK_AW);
      default: return {4'h0, 4'(14 + $urandom_range(0, 1)), 24'h0} + off + 32'($urandom_range(0, 3)) * (1 << CART_AW);
    endcase
  endfunction

  task automatic test_random;
    logic [31:0] a;
    for (int k = 0; k < 4; k++) begin
      check_access("rnd_init_ew",  0, 1, 32'h0200_0100 + 32'(4 * k), $urandom, 2'd2);
      check_access("rnd_init_iw",  0, 1, 32'h0300_0100 + 32'(4 * k), $urandom, 2'd2);
      check_access("rnd_init_pak", 0, 1, 32'h0800_0100 + 32'(4 * k), $urandom, 2'd2);
    end
    for (int k = 0; k < 16; k++)
      check_access("rnd_init_cart", 0, 1, 32'h0e00_0100 + 32'(k), $urandom, 2'd0);
    for (int n = 0; n < 150; n++) begin
      a = rand_addr($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        check_access("rnd_wr", 0, 1, a, $urandom, 2'($urandom_range(0, 3)));
      else
        check_access("rnd_rd", 1, 0, a, 32'h0, 2'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_iwram_word;
    test_ewram_byte;
    test_halfword;
    test_cart;
    test_errors;
    test_mirror;
    test_reset_mid_wait;
    test_back_to_back(32'h0300_0010);
    test_back_to_back(32'h0200_0000);
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
